// File: rtl/gcd_pkg.sv
// Shared types and defaults for the gcd feeder.
// State encoding plus width/timeout defaults.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH   = 32;
  localparam int unsigned GCD_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } gcd_state_e;

endpackage

// File: rtl/gcd_feeder_fifo.sv
// Operand-pair FIFO for the gcd feeder.
// Pointers wrap modulo DEPTH; occupancy kept separately.
module gcd_feeder_fifo #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign rdata = mem_q[rptr_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  // Next pointer and occupancy values.
  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  // Pointer and count state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/gcd_feeder.sv
// Front end for the gcd core: buffers pairs, launches, returns.
// GCD_FEEDER_TIMEOUT_EN adds a WAIT watchdog driving out_err.
module gcd_feeder
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH          = GCD_WIDTH,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = GCD_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_opa,
  input  logic [WIDTH-1:0]       in_opb,
  output logic [WIDTH-1:0]       gcd_opa,
  output logic [WIDTH-1:0]       gcd_opb,
  output logic                   gcd_start,
  input  logic                   gcd_done,
  input  logic [WIDTH-1:0]       gcd_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_opa,
  output logic [WIDTH-1:0]       out_opb,
  output logic [WIDTH-1:0]       out_result,
  output logic                   out_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count
);

  gcd_state_e state_q, state_d;

  logic               full, empty, push, pop;
  logic [2*WIDTH-1:0] head;
  logic [WIDTH-1:0]   head_a, head_b;
  logic               head_zero;
  logic               avail_q;

  logic [WIDTH-1:0] ga_q, ga_d;
  logic [WIDTH-1:0] gb_q, gb_d;
  logic [WIDTH-1:0] oa_q, oa_d;
  logic [WIDTH-1:0] ob_q, ob_d;
  logic [WIDTH-1:0] res_q, res_d;

`ifdef GCD_FEEDER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYCLES - 1);

  logic          err_q, err_d;
  logic [TW-1:0] cnt_q;
`endif

  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  gcd_feeder_fifo #(
    .W     (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({in_opa, in_opb}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign head_a    = head[2*WIDTH-1:WIDTH];
  assign head_b    = head[WIDTH-1:0];
  assign head_zero = (head_a == '0) || (head_b == '0);

  assign gcd_opa    = ga_q;
  assign gcd_opb    = gb_q;
  assign gcd_start  = (state_q == ISSUE);
  assign out_valid  = (state_q == HOLD);
  assign out_opa    = oa_q;
  assign out_opb    = ob_q;
  assign out_result = res_q;
  assign busy       = (state_q != IDLE);

`ifdef GCD_FEEDER_TIMEOUT_EN
  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif

  // Job sequencing: pop, bypass or launch, wait, hold result.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    ga_d    = ga_q;
    gb_d    = gb_q;
    oa_d    = oa_q;
    ob_d    = ob_q;
    res_d   = res_q;
`ifdef GCD_FEEDER_TIMEOUT_EN
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (avail_q && !empty) begin
          pop  = 1'b1;
          oa_d = head_a;
          ob_d = head_b;
`ifdef GCD_FEEDER_TIMEOUT_EN
          err_d = 1'b0;
`endif
          if (head_zero) begin
            res_d   = (head_a == '0) ? head_b : head_a;
            state_d = HOLD;
          end else begin
            ga_d    = head_a;
            gb_d    = head_b;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (gcd_done) begin
          res_d   = gcd_result;
          state_d = HOLD;
        end
`ifdef GCD_FEEDER_TIMEOUT_EN
        else if (cnt_q == TLIM) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = HOLD;
        end
`endif
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
`ifdef GCD_FEEDER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; avail_q lets a push settle
  // for a cycle before IDLE may take it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      avail_q <= 1'b0;
      ga_q    <= '0;
      gb_q    <= '0;
      oa_q    <= '0;
      ob_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      avail_q <= !empty;
      ga_q    <= ga_d;
      gb_q    <= gb_d;
      oa_q    <= oa_d;
      ob_q    <= ob_d;
      res_q   <= res_d;
    end
  end

`ifdef GCD_FEEDER_TIMEOUT_EN
  // Watchdog: cleared on launch, counts WAIT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      if (state_q == ISSUE)     cnt_q <= '0;
      else if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_feeder.sv
// Directed bench for gcd_feeder with a behavioural gcd core.
// Timeout scenario runs when GCD_FEEDER_TIMEOUT_EN is defined.
module tb_gcd_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_opa = '0;
  logic [31:0] in_opb = '0;
  logic [31:0] gcd_opa, gcd_opb;
  logic        gcd_start;
  logic        gcd_done = 1'b0;
  logic [31:0] gcd_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_opa, out_opb, out_result;
  logic        out_err;
  logic        busy;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;

  // core model state
  int          cyc = 0;
  int          done_cyc = -10;
  int          done_cnt = 0;
  int          start_cnt = 0;
  int          core_cnt = 0;
  bit          core_busy = 1'b0;
  bit          core_en = 1'b1;
  logic [31:0] core_res = '0;

  always #5 clk = ~clk;

  gcd_feeder #(
    .WIDTH          (32),
    .DEPTH          (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk        (clk),
    .reset      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opa     (in_opa),
    .in_opb     (in_opb),
    .gcd_opa    (gcd_opa),
    .gcd_opb    (gcd_opb),
    .gcd_start  (gcd_start),
    .gcd_done   (gcd_done),
    .gcd_result (gcd_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opa    (out_opa),
    .out_opb    (out_opb),
    .out_result (out_result),
    .out_err    (out_err),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  function automatic logic [31:0] ref_gcd(
    input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Behavioural core: fixed 20-cycle latency, not reset by the feeder.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gcd_done) begin
      done_cyc <= cyc;
      done_cnt <= done_cnt + 1;
    end
    gcd_done <= 1'b0;
    if (core_busy) begin
      if (core_cnt <= 1) begin
        gcd_done   <= core_en;
        gcd_result <= core_res;
        core_busy  <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
    if (gcd_start) begin
      core_busy <= 1'b1;
      core_cnt  <= 20;
      core_res  <= ref_gcd(gcd_opa, gcd_opb);
      start_cnt <= start_cnt + 1;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_pair(input logic [31:0] a, input logic [31:0] b,
                           input int bound, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_opa   = a;
    in_opb   = b;
    while (!in_ready && n < bound) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, gcd_start, out_err} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctl: got %b exp 10000",
               {in_ready, out_valid, busy, gcd_start, out_err});
    end
    checks++;
    if (fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d exp 0", fifo_count);
    end
    checks++;
    if ({gcd_opa, gcd_opb, out_opa, out_opb, out_result} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h %h %h exp 0",
               gcd_opa, gcd_opb, out_opa, out_opb, out_result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_core_job;
    bit ok;
    int n;
    int s0;
    out_ready = 1'b1;
    s0 = start_cnt;
    push_pair(32'd1075, 32'd255, 20, ok);
    n = 0;
    while (!gcd_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL start_latency: got %0d exp 3", n);
    end
    checks++;
    if (gcd_opa !== 32'd1075 || gcd_opb !== 32'd255) begin
      errors++;
      $display("FAIL start_ops: got %0d,%0d exp 1075,255", gcd_opa, gcd_opb);
    end
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || cyc !== done_cyc + 1) begin
      errors++;
      $display("FAIL done_latency: got v=%0d cyc=%0d exp v=1 cyc=%0d",
               out_valid, cyc, done_cyc + 1);
    end
    checks++;
    if (out_result !== 32'd5 || out_opa !== 32'd1075 ||
        out_opb !== 32'd255 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL core_result: got %0d (%0d,%0d) e=%0d exp 5 (1075,255) e=0",
               out_result, out_opa, out_opb, out_err);
    end
    checks++;
    if (start_cnt !== s0 + 1) begin
      errors++;
      $display("FAIL start_pulses: got %0d exp %0d", start_cnt - s0, 1);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL core_release: got v=%0d b=%0d exp 0 0", out_valid, busy);
    end
  endtask

  task automatic test_zero_bypass;
    bit ok;
    int s0;
    logic [31:0] za [2];
    logic [31:0] zb [2];
    logic [31:0] zr [2];
    za = '{32'd0, 32'd0};
    zb = '{32'd42, 32'd0};
    zr = '{32'd42, 32'd0};
    s0 = start_cnt;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      push_pair(za[k], zb[k], 20, ok);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL zero_early_%0d: got %0d exp 0", k, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_result !== zr[k] ||
          out_opa !== za[k] || out_opb !== zb[k]) begin
        errors++;
        $display("FAIL zero_result_%0d: got v=%0d r=%0d (%0d,%0d) exp v=1 r=%0d",
                 k, out_valid, out_result, out_opa, out_opb, zr[k]);
      end
    end
    repeat (3) @(negedge clk);
    checks++;
    if (start_cnt !== s0) begin
      errors++;
      $display("FAIL zero_no_start: got %0d starts exp 0", start_cnt - s0);
    end
  endtask

  task automatic test_backpressure_stream;
    bit ok;
    bit ok6;
    logic [31:0] sa [6];
    logic [31:0] sb [6];
    logic [31:0] sr [6];
    sa = '{32'd12, 32'd17, 32'd100, 32'd9, 32'd48, 32'd7};
    sb = '{32'd18, 32'd5,  32'd75,  32'd9, 32'd36, 32'd49};
    sr = '{32'd6,  32'd1,  32'd25,  32'd9, 32'd12, 32'd7};
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push_pair(sa[i], sb[i], 20, ok);
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL stream_push_%0d: got ready=%0d exp 1", i, ok);
      end
    end
    fork
      push_pair(sa[5], sb[5], 600, ok6);
      begin
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (out_valid !== 1'b1 || fifo_count !== 3'd4 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL hold_full: got v=%0d cnt=%0d rdy=%0d exp 1 4 0",
                   out_valid, fifo_count, in_ready);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 32'd6 ||
            out_opa !== 32'd12 || out_opb !== 32'd18 || fifo_count !== 3'd4) begin
          errors++;
          $display("FAIL hold_stable: got v=%0d r=%0d (%0d,%0d) c=%0d exp 1 6 (12,18) 4",
                   out_valid, out_result, out_opa, out_opb, fifo_count);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
          n = 0;
          while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
          end
          checks++;
          if (out_valid !== 1'b1 || out_result !== sr[k] ||
              out_opa !== sa[k] || out_opb !== sb[k]) begin
            errors++;
            $display("FAIL stream_res_%0d: got v=%0d r=%0d (%0d,%0d) exp r=%0d (%0d,%0d)",
                     k, out_valid, out_result, out_opa, out_opb,
                     sr[k], sa[k], sb[k]);
          end
          @(posedge clk);
          #1;
        end
      end
    join
    checks++;
    if (ok6 !== 1'b1) begin
      errors++;
      $display("FAIL stream_push_5: got ready=%0d exp 1", ok6);
    end
  endtask

  task automatic test_reset_midjob;
    bit ok;
    bit seen_v;
    bit seen_b;
    int d0;
    out_ready = 1'b1;
    push_pair(32'd21, 32'd14, 20, ok);
    push_pair(32'd8,  32'd12, 20, ok);
    push_pair(32'd30, 32'd45, 20, ok);
    push_pair(32'd6,  32'd4,  20, ok);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || fifo_count !== 3'd3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midjob_pre: got b=%0d c=%0d v=%0d exp 1 3 0",
               busy, fifo_count, out_valid);
    end
    d0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 3'd0 || busy !== 1'b0 || out_valid !== 1'b0 ||
        gcd_start !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: got c=%0d b=%0d v=%0d s=%0d r=%0d exp 0 0 0 0 1",
               fifo_count, busy, out_valid, gcd_start, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen_v = 1'b0;
    seen_b = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_v |= out_valid;
      seen_b |= busy;
    end
    checks++;
    if (seen_v !== 1'b0 || seen_b !== 1'b0 || done_cnt !== d0 + 1) begin
      errors++;
      $display("FAIL late_done: got v=%0d b=%0d dones=%0d exp 0 0 1",
               seen_v, seen_b, done_cnt - d0);
    end
  endtask

`ifdef GCD_FEEDER_TIMEOUT_EN
  task automatic test_timeout;
    bit ok;
    int n;
    core_en = 1'b0;
    out_ready = 1'b1;
    push_pair(32'd20, 32'd8, 20, ok);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 20 || out_err !== 1'b1 || out_result !== 32'd0) begin
      errors++;
      $display("FAIL timeout: got n=%0d e=%0d r=%0d exp 20 1 0",
               n, out_err, out_result);
    end
    @(negedge clk);
    checks++;
    if (out_err !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got e=%0d v=%0d exp 0 0", out_err, out_valid);
    end
    repeat (30) @(negedge clk);
    core_en = 1'b1;
    push_pair(32'd20, 32'd8, 20, ok);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'd4 || out_err !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout: got v=%0d r=%0d e=%0d exp 1 4 0",
               out_valid, out_result, out_err);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_core_job();
    test_zero_bypass();
    test_backpressure_stream();
    test_reset_midjob();
`ifdef GCD_FEEDER_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
